pass_unlock_ctrl: RTL

Access-control stage placed directly downstream of the serial password detector. It consumes the detector's one-cycle Moore match output and turns it into a timed unlock. Each attempt gets a bounded observation window. Failed attempts are counted, and after too many failures the block enters a timed lockout during which matches are ignored. Only the block's outputs drive the door/enable logic; the detector itself is unchanged.

---
 rtl/pass_unlock_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pass_unlock_ctrl.sv
// pass_unlock_ctrl: turns the password detector's match pulse into a timed
// unlock with per-attempt window, failure counting and timed lockout.
// Optional feature macro: PASS_UNLOCK_EXTEND_EN (match while unlocked restarts the unlock period).
module pass_unlock_ctrl #(
  parameter int WINDOW         = 16,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           arm,
  input  logic                           match,
  output logic                           armed,
  output logic                           unlocked,
  output logic                           locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

  localparam int MAX_WU =
    (WINDOW > UNLOCK_CYCLES) ? WINDOW : UNLOCK_CYCLES;
  localparam int MAX_C =
    (MAX_WU > LOCKOUT_CYCLES) ? MAX_WU : LOCKOUT_CYCLES;
  localparam int CW = $clog2(MAX_C);
  localparam int FW = $clog2(MAX_FAILS + 1);

  localparam logic [CW-1:0] WIN_LAST  = CW'(WINDOW - 1);
  localparam logic [CW-1:0] UNL_LAST  = CW'(UNLOCK_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCKOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
  localparam logic [FW-1:0] FAIL_ONE  = FW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [FW-1:0] fail_q;
  logic [FW-1:0] fail_d;
  logic [FW-1:0] fail_inc;
  logic          win_end;
  logic          unl_end;
  logic          lock_end;

  // Saturating increment of the consecutive-failure count
  always_comb begin
    fail_inc = fail_q;
    if (fail_q < FAIL_MAX) begin
      fail_inc = fail_q + FAIL_ONE;
    end
  end

  // Terminal-count flags of the shared cycle counter
  always_comb begin
    win_end  = (cnt_q == WIN_LAST);
    unl_end  = (cnt_q == UNL_LAST);
    lock_end = (cnt_q == LOCK_LAST);
  end

  // Next state, counter and failure count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
          cnt_d   = '0;
        end
      end
      ARMED: begin
        if (match) begin
          state_d = UNLOCKED;
          cnt_d   = '0;
          fail_d  = '0;
        end else if (win_end) begin
          cnt_d  = '0;
          fail_d = fail_inc;
          if (fail_inc == FAIL_MAX) begin
            state_d = LOCKOUT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      UNLOCKED: begin
`ifdef PASS_UNLOCK_EXTEND_EN
        if (match) begin
          cnt_d = '0;
        end else if (unl_end) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`else
        if (unl_end) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end
      LOCKOUT: begin
        if (lock_end) begin
          state_d = IDLE;
          cnt_d   = '0;
          fail_d  = '0;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          fail_d = FAIL_MAX;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        fail_d  = '0;
      end
    endcase
  end

  // State, counter and registered output decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fail_q     <= '0;
      armed      <= 1'b0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fail_q     <= fail_d;
      armed      <= (state_d == ARMED);
      unlocked   <= (state_d == UNLOCKED);
      locked_out <= (state_d == LOCKOUT);
    end
  end

  assign fail_cnt = fail_q;

endmodule
